cpri_pkg_gen: RTL and testbench
===============================

CPRI_PKG_GEN -- requirements
Module: cpri_pkg_gen

Parameters
REQ-001 NUM_ANT, default 4, number of antenna lanes (1..8).
REQ-002 IQ_W, default 14, compressed RE width (8..16).
REQ-003 ADDR_W, default 7, write-address width; 2^ADDR_W SHALL be at least 4*NUM_ANT.

Interface
REQ-004 clk  in  1  sole clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_vld/i_sop/i_eop  in  1 each  input RE beat qualifier, PRB start, PRB end; common to all lanes.
REQ-007 i_data  in  NUM_ANT*IQ_W  compressed REs; lane a occupies [a*IQ_W +: IQ_W].
REQ-008 i_shift  in  NUM_ANT*4  per-lane block exponent; sampled on the sop beat.
REQ-009 i_info  in  NUM_ANT*8  per-lane info byte; sampled on the sop beat.
REQ-010 i_ch_type 4 / i_slot_idx 7 / i_sym_idx 4 / i_prb_idx 9  in  header fields; sampled on the sop beat.
REQ-011 i_ant_mask  in  NUM_ANT  lane enable (1 = lane is emitted); sampled on the sop beat.
REQ-012 o_wen/o_waddr/o_wdata/o_wlast  out  1/ADDR_W/64/1  CPRI buffer write port.
REQ-013 o_ovf  out  1  one-cycle pulse when a PRB is dropped because no bank is free.
REQ-014 o_err_len  out  1  one-cycle pulse on a malformed PRB.
REQ-015 o_drop_cnt  out  16  saturating count of PRBs dropped by overflow or length error.
REQ-016 o_busy  out  1  high while the reader is not IDLE.

Function
REQ-017 A PRB SHALL be exactly 12 i_vld beats; sop on beat 0, eop on beat 11; non-vld cycles inside a PRB are ignored.
REQ-018 The block SHALL hold two ping-pong banks, each storing 12 REs x NUM_ANT plus the sampled header fields, shift, info and mask.
REQ-019 A PRB SHALL commit on its eop beat; the write-bank pointer toggles on commit.
REQ-020 A sop beat while a PRB is open SHALL discard the open PRB, pulse o_err_len, increment o_drop_cnt, and start the new PRB.
REQ-021 eop at beat index other than 11, or beat 12 arriving without eop, SHALL discard the PRB, pulse o_err_len and increment o_drop_cnt.
REQ-022 A sop whose target bank is still unread SHALL drop that whole PRB, pulse o_ovf on the sop cycle and increment o_drop_cnt.
REQ-023 A PRB with i_ant_mask == 0 SHALL be discarded silently on commit: no write, no flag.
REQ-024 Reader FSM states: IDLE, HDR, DATA.
- IDLE -> HDR in the cycle after a commit, or immediately when a bank is pending.
- HDR -> DATA after 1 word.
- DATA -> HDR for the next enabled lane after 3 words.
- Last lane -> IDLE, or -> HDR of the other bank if it is pending (no idle cycle).
REQ-025 Enabled lanes SHALL be emitted in ascending index; masked lanes SHALL produce no words.
REQ-026 Header word bit fields:
- [63:60] ch_type
- [59:57] lane index
- [56:50] slot
- [49:46] sym
- [45:37] prb
- [36:29] info
- [28:4] zero
- [3:0] shift
REQ-027 Data word j (j = 0..2) SHALL carry RE 4j in [15:0] through RE 4j+3 in [63:48], each RE sign-extended from IQ_W to 16 bits.
REQ-028 o_waddr SHALL be 0 on the first word of a PRB and increment by 1 per word up to 4*Nen-1 (Nen = enabled lanes); o_wlast SHALL be high on that last word only.
REQ-029 o_wen SHALL be high exactly on valid words; o_wdata and o_waddr SHALL hold their last value when o_wen is low.
REQ-030 Output SHALL be registered: the first o_wen occurs 2 cycles after the eop edge when the reader is IDLE.
REQ-031 Sustained rate: one PRB per 4*Nen cycles; faster input SHALL overflow per REQ-022, never corrupt a bank under read.
REQ-032 o_drop_cnt SHALL saturate at 16'hFFFF; simultaneous o_err_len and o_ovf events SHALL increment it by 1 per dropped PRB.

Reset
REQ-033 While rst_n is low, all outputs SHALL be 0, the FSM SHALL be IDLE, both banks SHALL be empty and the write pointer SHALL be bank 0.
REQ-034 Reset asserted mid-PRB or mid-read SHALL abandon all data; no partial write SHALL follow deassertion.

Verification
REQ-035 NUM_ANT=4, mask 4'hF, one PRB, RE value = 16*lane+index -> 16 words, waddr 0..15, wlast at 15; lane-2 header [59:57]=2; lane-1 word 0 = {0x0013,0x0012,0x0011,0x0010}.
REQ-036 Mask 4'b0101 -> 8 words, lanes 0 and 2 only, wlast at waddr 7.
REQ-037 Back-to-back PRBs, 12-cycle spacing, mask 4'hF -> PRB 1 and 2 written, PRB 3 dropped: o_ovf pulse at its sop, o_drop_cnt=1.
REQ-038 eop on beat 9 -> o_err_len pulse, no o_wen, o_drop_cnt=1; next valid PRB is written normally.
REQ-039 IQ_W=14, RE 14'h2000 -> output field 16'hE000 (sign extension).
REQ-040 rst_n low during lane 1 data -> all outputs 0 next cycle; after release, no o_wen until a new eop commits.

Source files
------------

// File: rtl/cpri_pkg_gen.sv
// CPRI packet generator: gathers 12-RE PRBs for NUM_ANT lanes into two ping-pong banks
// and streams each committed PRB as header + 3 data words per enabled lane.
module cpri_pkg_gen #(
    parameter int unsigned NUM_ANT = 4,
    parameter int unsigned IQ_W    = 14,
    parameter int unsigned ADDR_W  = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vld,
    input  logic                    i_sop,
    input  logic                    i_eop,
    input  logic [NUM_ANT*IQ_W-1:0] i_data,
    input  logic [NUM_ANT*4-1:0]    i_shift,
    input  logic [NUM_ANT*8-1:0]    i_info,
    input  logic [3:0]              i_ch_type,
    input  logic [6:0]              i_slot_idx,
    input  logic [3:0]              i_sym_idx,
    input  logic [8:0]              i_prb_idx,
    input  logic [NUM_ANT-1:0]      i_ant_mask,
    output logic                    o_wen,
    output logic [ADDR_W-1:0]       o_waddr,
    output logic [63:0]             o_wdata,
    output logic                    o_wlast,
    output logic                    o_ovf,
    output logic                    o_err_len,
    output logic [15:0]             o_drop_cnt,
    output logic                    o_busy
);

    localparam int unsigned LANE_W  = 4;
    localparam int unsigned MEM_D   = 32;
    localparam int unsigned LAST_RE = 11;

    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} rd_state_t;

    // Write side
    logic                    open_q;
    logic [3:0]              cnt_q;
    logic                    wbank_q;
    logic [1:0]              full_q;
    logic [NUM_ANT*IQ_W-1:0] re_mem [MEM_D];
    logic [3:0]              ch_q    [2];
    logic [6:0]              slot_q  [2];
    logic [3:0]              sym_q   [2];
    logic [8:0]              prb_q   [2];
    logic [NUM_ANT*4-1:0]    shift_q [2];
    logic [NUM_ANT*8-1:0]    info_q  [2];
    logic [NUM_ANT-1:0]      mask_q  [2];

    // Read side
    rd_state_t               state_q;
    logic                    rbank_q;
    logic [LANE_W-1:0]       lane_q;
    logic [1:0]              wcnt_q;
    logic [ADDR_W-1:0]       waddr_q;

    logic                    sop_c, err_old_c, ovf_c, start_c, err_new_c;
    logic                    beat_c, err_beat_c, commit_c, keep_c, store_c;
    logic [1:0]              drops_c;
    logic [16:0]             drop_sum_c;
    logic [4:0]              widx_c;
    logic [LANE_W-1:0]       nxt_lane_c, oth_first_c, rd_first_c;
    logic                    rd_done_c;
    logic [1:0]              done_vec_c, set_vec_c;
    logic [63:0]             hdr_c, dat_c;

    // Lowest enabled lane at or above 'from'; NUM_ANT when none remains
    function automatic logic [LANE_W-1:0] first_lane(input logic [NUM_ANT-1:0] mask,
                                                     input logic [LANE_W-1:0] from);
        logic [LANE_W-1:0] r;
        r = LANE_W'(NUM_ANT);
        for (int i = int'(NUM_ANT) - 1; i >= 0; i--) begin
            if (mask[i] && (LANE_W'(i) >= from)) r = LANE_W'(i);
        end
        return r;
    endfunction

    // Input framing: classify each beat as start, store, commit or drop
    always_comb begin
        sop_c      = i_vld & i_sop;
        err_old_c  = sop_c & open_q;
        ovf_c      = sop_c & full_q[wbank_q];
        start_c    = sop_c & ~full_q[wbank_q];
        err_new_c  = start_c & i_eop;
        beat_c     = i_vld & ~i_sop & open_q;
        err_beat_c = beat_c & (i_eop ? (cnt_q != 4'(LAST_RE)) : (cnt_q == 4'(LAST_RE + 1)));
        commit_c   = beat_c & i_eop & (cnt_q == 4'(LAST_RE));
        keep_c     = commit_c & (|mask_q[wbank_q]);
        store_c    = (start_c & ~i_eop) | (beat_c & ~err_beat_c);
        drops_c    = 2'(err_old_c) + 2'(ovf_c) + 2'(err_new_c) + 2'(err_beat_c);
        drop_sum_c = 17'(o_drop_cnt) + 17'(drops_c);
        widx_c     = {wbank_q, sop_c ? 4'd0 : cnt_q};
        set_vec_c  = keep_c ? (2'b01 << wbank_q) : 2'b00;
        done_vec_c = rd_done_c ? (2'b01 << rbank_q) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q     <= 1'b0;
            cnt_q      <= 4'd0;
            wbank_q    <= 1'b0;
            full_q     <= 2'b00;
            o_ovf      <= 1'b0;
            o_err_len  <= 1'b0;
            o_drop_cnt <= 16'd0;
        end else begin
            o_ovf     <= ovf_c;
            o_err_len <= err_old_c | err_new_c | err_beat_c;
            if (drops_c != 2'd0) o_drop_cnt <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
            if (sop_c) begin
                open_q <= start_c & ~i_eop;
                cnt_q  <= 4'd1;
            end else if (err_beat_c | commit_c) begin
                open_q <= 1'b0;
            end else if (beat_c) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (keep_c) wbank_q <= ~wbank_q;
            full_q <= (full_q & ~done_vec_c) | set_vec_c;
        end
    end

    // Bank storage; only the free write bank is ever touched
    always_ff @(posedge clk) begin
        if (store_c) re_mem[widx_c] <= i_data;
        if (start_c) begin
            ch_q[wbank_q]    <= i_ch_type;
            slot_q[wbank_q]  <= i_slot_idx;
            sym_q[wbank_q]   <= i_sym_idx;
            prb_q[wbank_q]   <= i_prb_idx;
            shift_q[wbank_q] <= i_shift;
            info_q[wbank_q]  <= i_info;
            mask_q[wbank_q]  <= i_ant_mask;
        end
    end

    // Read-side word assembly
    always_comb begin
        int unsigned       ln;
        logic [IQ_W-1:0]   re;
        ln          = 32'(lane_q);
        rd_first_c  = first_lane(mask_q[rbank_q], LANE_W'(0));
        nxt_lane_c  = first_lane(mask_q[rbank_q], lane_q + LANE_W'(1));
        oth_first_c = first_lane(mask_q[~rbank_q], LANE_W'(0));
        rd_done_c   = (state_q == DATA) && (wcnt_q == 2'd2) && (nxt_lane_c == LANE_W'(NUM_ANT));
        hdr_c       = {ch_q[rbank_q], lane_q[2:0], slot_q[rbank_q], sym_q[rbank_q], prb_q[rbank_q],
                       info_q[rbank_q][ln*8 +: 8], 25'd0, shift_q[rbank_q][ln*4 +: 4]};
        dat_c       = 64'd0;
        for (int k = 0; k < 4; k++) begin
            re = re_mem[{rbank_q, 4'(32'(wcnt_q) * 4 + 32'(k))}][ln*IQ_W +: IQ_W];
            dat_c[k*16 +: 16] = 16'($signed(re));
        end
    end

    // Reader FSM with registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rbank_q <= 1'b0;
            lane_q  <= '0;
            wcnt_q  <= 2'd0;
            waddr_q <= '0;
            o_wen   <= 1'b0;
            o_wlast <= 1'b0;
            o_waddr <= '0;
            o_wdata <= 64'd0;
            o_busy  <= 1'b0;
        end else begin
            o_wen   <= 1'b0;
            o_wlast <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (full_q[rbank_q]) begin
                        state_q <= HDR;
                        lane_q  <= rd_first_c;
                        waddr_q <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                HDR: begin
                    o_wen   <= 1'b1;
                    o_wdata <= hdr_c;
                    o_waddr <= waddr_q;
                    waddr_q <= waddr_q + ADDR_W'(1);
                    wcnt_q  <= 2'd0;
                    state_q <= DATA;
                end
                DATA: begin
                    o_wen   <= 1'b1;
                    o_wdata <= dat_c;
                    o_waddr <= waddr_q;
                    waddr_q <= waddr_q + ADDR_W'(1);
                    wcnt_q  <= wcnt_q + 2'd1;
                    if (wcnt_q == 2'd2) begin
                        if (nxt_lane_c != LANE_W'(NUM_ANT)) begin
                            lane_q  <= nxt_lane_c;
                            state_q <= HDR;
                        end else begin
                            o_wlast <= 1'b1;
                            rbank_q <= ~rbank_q;
                            waddr_q <= '0;
                            if (full_q[~rbank_q]) begin
                                lane_q  <= oth_first_c;
                                state_q <= HDR;
                            end else begin
                                state_q <= IDLE;
                                o_busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpri_pkg_gen.sv
// Bench for cpri_pkg_gen: directed steps plus randomized PRBs checked against a word-list model.
module tb_cpri_pkg_gen;

    localparam int NA = 4;
    localparam int IW = 14;
    localparam int AW = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_vld, i_sop, i_eop;
    logic [NA*IW-1:0]  i_data;
    logic [NA*4-1:0]   i_shift;
    logic [NA*8-1:0]   i_info;
    logic [3:0]        i_ch_type;
    logic [6:0]        i_slot_idx;
    logic [3:0]        i_sym_idx;
    logic [8:0]        i_prb_idx;
    logic [NA-1:0]     i_ant_mask;
    logic              o_wen;
    logic [AW-1:0]     o_waddr;
    logic [63:0]       o_wdata;
    logic              o_wlast;
    logic              o_ovf;
    logic              o_err_len;
    logic [15:0]       o_drop_cnt;
    logic              o_busy;

    cpri_pkg_gen #(.NUM_ANT(NA), .IQ_W(IW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop),
        .i_data(i_data), .i_shift(i_shift), .i_info(i_info), .i_ch_type(i_ch_type),
        .i_slot_idx(i_slot_idx), .i_sym_idx(i_sym_idx), .i_prb_idx(i_prb_idx),
        .i_ant_mask(i_ant_mask), .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_wlast(o_wlast), .o_ovf(o_ovf), .o_err_len(o_err_len), .o_drop_cnt(o_drop_cnt),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0]   d;
        logic [AW-1:0] a;
        logic          l;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] cap [128];
    int          n_words = 0, first_cyc = 0, last_addr = -1;
    int          ovf_pulses = 0, err_pulses = 0, ovf_cyc = 0;
    int          sop_cyc = 0, eop_cyc = 0;

    // Current PRB stimulus
    logic [3:0]    p_ch;
    logic [6:0]    p_slot;
    logic [3:0]    p_sym;
    logic [8:0]    p_prb;
    logic [7:0]    p_info  [NA];
    logic [3:0]    p_shift [NA];
    logic [NA-1:0] p_mask;
    logic [IW-1:0] p_re    [12][NA];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sx(input logic [IW-1:0] v);
        int s;
        s = int'(v);
        if (s >= (1 << (IW - 1))) s = s - (1 << IW);
        return 16'(s);
    endfunction

    // Expected write stream for the current PRB
    task automatic push_expected();
        int nen, addr;
        wr_t w;
        nen  = $countones(p_mask);
        addr = 0;
        for (int a = 0; a < NA; a++) begin
            if (p_mask[a]) begin
                w.d = {p_ch, 3'(a), p_slot, p_sym, p_prb, p_info[a], 25'd0, p_shift[a]};
                w.a = AW'(addr);
                w.l = 1'b0;
                exp_q.push_back(w);
                addr++;
                for (int j = 0; j < 3; j++) begin
                    w.d = 64'd0;
                    for (int k = 0; k < 4; k++) w.d[16*k +: 16] = sx(p_re[4*j+k][a]);
                    w.a = AW'(addr);
                    w.l = (addr == 4*nen - 1);
                    exp_q.push_back(w);
                    addr++;
                end
            end
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (o_ovf) begin
            ovf_pulses++;
            ovf_cyc = cyc;
        end
        if (o_err_len) err_pulses++;
        if (o_wen) begin
            n_words++;
            if (o_waddr == '0) first_cyc = cyc;
            cap[o_waddr] = o_wdata;
            if (o_wlast) last_addr = int'(o_waddr);
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL spurious_wen observed waddr=%0d expected no write", o_waddr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wdata", o_wdata, e.d);
                check("waddr", 64'(o_waddr), 64'(e.a));
                check("wlast", 64'(o_wlast), 64'(e.l));
            end
        end
    end

    task automatic garbage_hdr();
        i_shift    = NA*4'($urandom);
        i_info     = NA*8'($urandom);
        i_ch_type  = 4'($urandom);
        i_slot_idx = 7'($urandom);
        i_sym_idx  = 4'($urandom);
        i_prb_idx  = 9'($urandom);
        i_ant_mask = NA'($urandom);
    endtask

    task automatic idle();
        @(negedge clk);
        i_vld  = 1'b0;
        i_sop  = 1'b0;
        i_eop  = 1'b0;
        i_data = (NA*IW)'({$urandom, $urandom});
        garbage_hdr();
    endtask

    task automatic rand_prb();
        p_ch   = 4'($urandom);
        p_slot = 7'($urandom);
        p_sym  = 4'($urandom);
        p_prb  = 9'($urandom);
        p_mask = NA'($urandom);
        for (int a = 0; a < NA; a++) begin
            p_info[a]  = 8'($urandom);
            p_shift[a] = 4'($urandom);
            for (int b = 0; b < 12; b++) p_re[b][a] = IW'($urandom);
        end
    endtask

    // Drive beats 0..last_beat with eop on last_beat
    task automatic send_prb(input int last_beat, input bit gaps, input bit keep);
        if (keep && last_beat == 11 && p_mask != '0) push_expected();
        for (int b = 0; b <= last_beat; b++) begin
            if (gaps && b > 0) repeat ($urandom_range(0, 2)) idle();
            @(negedge clk);
            i_vld = 1'b1;
            i_sop = (b == 0);
            i_eop = (b == last_beat);
            for (int a = 0; a < NA; a++) i_data[a*IW +: IW] = p_re[b][a];
            if (b == 0) begin
                i_ch_type  = p_ch;
                i_slot_idx = p_slot;
                i_sym_idx  = p_sym;
                i_prb_idx  = p_prb;
                i_ant_mask = p_mask;
                for (int a = 0; a < NA; a++) begin
                    i_shift[a*4 +: 4] = p_shift[a];
                    i_info[a*8 +: 8]  = p_info[a];
                end
                sop_cyc = cyc + 1;
            end else begin
                garbage_hdr();
            end
            if (b == last_beat) eop_cyc = cyc + 1;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || o_busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        assert (t < 400) else begin
            failures++;
            $error("FAIL %s observed pending=%0d expected 0", tag, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        idle();
    endtask

    initial begin : stim
        int n0, e0, o0, s3, t;
        rst_n = 1'b0;
        i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_data = '0;
        i_shift = '0; i_info = '0; i_ch_type = '0; i_slot_idx = '0;
        i_sym_idx = '0; i_prb_idx = '0; i_ant_mask = '0;
        repeat (2) @(negedge clk);
        check("rst_wen", 64'(o_wen), 64'(0));
        check("rst_waddr", 64'(o_waddr), 64'(0));
        check("rst_wdata", o_wdata, 64'd0);
        check("rst_wlast", 64'(o_wlast), 64'(0));
        check("rst_ovf", 64'(o_ovf), 64'(0));
        check("rst_err", 64'(o_err_len), 64'(0));
        check("rst_drop", 64'(o_drop_cnt), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) idle();

        // Full mask, RE = 16*lane + index
        rand_prb();
        p_mask = 4'hF;
        for (int b = 0; b < 12; b++) for (int a = 0; a < NA; a++) p_re[b][a] = IW'(16*a + b);
        n0 = n_words;
        send_prb(11, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("busy_during_read", 64'(o_busy), 64'(1));
        drain("drain_full");
        check("latency", 64'(first_cyc - eop_cyc), 64'(2));
        check("words_full", 64'(n_words - n0), 64'(16));
        check("wlast_full", 64'(last_addr), 64'(15));
        check("lane2_hdr_idx", 64'(cap[8][59:57]), 64'(2));
        check("lane1_word0", cap[5], 64'h0013_0012_0011_0010);

        // Sparse mask
        rand_prb();
        p_mask = 4'b0101;
        n0 = n_words;
        send_prb(11, 1'b1, 1'b1);
        idle();
        drain("drain_sparse");
        check("words_sparse", 64'(n_words - n0), 64'(8));
        check("wlast_sparse", 64'(last_addr), 64'(7));
        check("sparse_hdr_idx", 64'(cap[4][59:57]), 64'(2));

        // Sign extension
        rand_prb();
        p_mask = 4'b0001;
        p_re[0][0] = 14'h2000;
        send_prb(11, 1'b0, 1'b1);
        idle();
        drain("drain_sext");
        check("sign_ext", 64'(cap[1][15:0]), 64'(16'hE000));

        // Short PRB: eop on beat 9
        apply_reset();
        rand_prb();
        p_mask = 4'hF;
        n0 = n_words;
        e0 = err_pulses;
        send_prb(9, 1'b0, 1'b0);
        idle();
        check("err_len_pulse", 64'(o_err_len), 64'(1));
        repeat (10) idle();
        check("err_pulse_count", 64'(err_pulses - e0), 64'(1));
        check("err_drop_cnt", 64'(o_drop_cnt), 64'(1));
        check("err_no_words", 64'(n_words - n0), 64'(0));
        rand_prb();
        p_mask = NA'($urandom_range(1, 15));
        send_prb(11, 1'b1, 1'b1);
        idle();
        drain("drain_after_err");
        check("words_after_err", 64'(n_words - n0), 64'(4 * $countones(p_mask)));
        check("drop_after_err", 64'(o_drop_cnt), 64'(1));

        // Three back-to-back PRBs, third overflows
        apply_reset();
        n0 = n_words;
        o0 = ovf_pulses;
        e0 = err_pulses;
        rand_prb(); p_mask = 4'hF; send_prb(11, 1'b0, 1'b1);
        rand_prb(); p_mask = 4'hF; send_prb(11, 1'b0, 1'b1);
        rand_prb(); p_mask = 4'hF; send_prb(11, 1'b0, 1'b0);
        s3 = sop_cyc;
        idle();
        drain("drain_b2b");
        check("ovf_count", 64'(ovf_pulses - o0), 64'(1));
        check("ovf_at_sop", 64'(ovf_cyc), 64'(s3));
        check("ovf_drop_cnt", 64'(o_drop_cnt), 64'(1));
        check("ovf_no_err", 64'(err_pulses - e0), 64'(0));
        check("b2b_words", 64'(n_words - n0), 64'(32));

        // Randomized well-spaced PRBs
        o0 = ovf_pulses;
        e0 = err_pulses;
        for (int i = 0; i < 12; i++) begin
            rand_prb();
            if ($urandom_range(0, 5) == 0) p_mask = '0;
            send_prb(11, 1'b1, 1'b1);
            idle();
            drain("drain_rand");
        end
        check("rand_drop_cnt", 64'(o_drop_cnt), 64'(1));
        check("rand_no_ovf", 64'(ovf_pulses - o0), 64'(0));
        check("rand_no_err", 64'(err_pulses - e0), 64'(0));

        // Reset during lane-1 data
        rand_prb();
        p_mask = 4'hF;
        send_prb(11, 1'b0, 1'b1);
        idle();
        t = 0;
        while (!(o_wen && o_waddr == AW'(5)) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_lane1", 64'(t < 100), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_wen", 64'(o_wen), 64'(0));
        check("mid_rst_waddr", 64'(o_waddr), 64'(0));
        check("mid_rst_wdata", o_wdata, 64'd0);
        check("mid_rst_wlast", 64'(o_wlast), 64'(0));
        check("mid_rst_busy", 64'(o_busy), 64'(0));
        check("mid_rst_drop", 64'(o_drop_cnt), 64'(0));
        repeat (3) @(negedge clk);
        n0 = n_words;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_no_words", 64'(n_words - n0), 64'(0));
        check("post_rst_busy", 64'(o_busy), 64'(0));
        rand_prb();
        p_mask = 4'b1010;
        send_prb(11, 1'b1, 1'b1);
        idle();
        drain("drain_post_rst");
        check("post_rst_words", 64'(n_words - n0), 64'(8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

endmodule
